uart_tx_ctrl: RTL and testbench

Transmit-side frame controller of the UART TX path. It sits directly downstream of the parity calculator and sits alongside it on the same TX clock. It accepts a parallel data word and serializes it onto the line as one frame: start bit, data bits LSB first, optional parity bit, stop bit(s). The parity bit is taken from the parity calculator's registered output. One line bit is driven per `clk` cycle, with `clk` being the TX (baud-rate) clock.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_serializer.sv | 51 +++++
 rtl/uart_tx_ctrl.sv | 112 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit path.
// Imported by the frame controller and its serializer.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // A one-bit word still needs a one-bit counter.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART transmitter.
// bit_out is the next data bit to drive; last_bit flags the final data bit.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] p_data,
   output logic                  bit_out,
   output logic                  last_bit
);

   localparam int            CW   = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;

   // Shift register and counter; the counter saturates at LAST so it never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= p_data;
         cnt   <= '0;
      end else begin
         if (shift) begin
            shreg <= shreg >> 1'b1;
         end else begin
            shreg <= shreg;
         end
         if (clr) begin
            cnt <= '0;
         end else if (shift && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= cnt;
         end
      end
   end

   assign bit_out  = shreg[0];
   assign last_bit = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity,
// STOP_BITS stop bits. Every output is registered and reflects the line bit now on the wire.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_bit,
   output logic                  tx_out,
   output logic                  busy
);

   localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

   tx_state_e  state;
   logic       par_en_q;
   logic [1:0] stop_cnt;
   logic       load;
   logic       shift;
   logic       clr;
   logic       bit_out;
   logic       last_bit;

   uart_tx_serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_serializer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .shift    (shift),
      .clr      (clr),
      .p_data   (p_data),
      .bit_out  (bit_out),
      .last_bit (last_bit)
   );

   // Leaving START puts bit 0 on the line, so the first shift and the counter clear coincide.
   always_comb begin
      load  = (state == IDLE) && data_valid;
      shift = (state == START) || ((state == DATA) && !last_bit);
      clr   = (state == START);
   end

   // Frame FSM; each branch registers the line level of the state it enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_out   <= IDLE_LEVEL;
         busy     <= 1'b0;
         par_en_q <= 1'b0;
         stop_cnt <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (data_valid) begin
                  state    <= START;
                  tx_out   <= START_BIT;
                  busy     <= 1'b1;
                  par_en_q <= par_en;
               end else begin
                  tx_out <= IDLE_LEVEL;
                  busy   <= 1'b0;
               end
            end
            START: begin
               state  <= DATA;
               tx_out <= bit_out;
            end
            DATA: begin
               if (last_bit) begin
                  if (par_en_q) begin
                     state  <= PARITY;
                     tx_out <= par_bit;
                  end else begin
                     state    <= STOP;
                     tx_out   <= STOP_BIT;
                     stop_cnt <= 2'd0;
                  end
               end else begin
                  tx_out <= bit_out;
               end
            end
            PARITY: begin
               state    <= STOP;
               tx_out   <= STOP_BIT;
               stop_cnt <= 2'd0;
            end
            STOP: begin
               if (stop_cnt == STOP_LAST) begin
                  state  <= IDLE;
                  tx_out <= IDLE_LEVEL;
                  busy   <= 1'b0;
               end else begin
                  stop_cnt <= stop_cnt + 2'd1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= IDLE_LEVEL;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one-stop-bit and two-stop-bit instances,
// expected line sequences written out by hand as strings of '0'/'1'.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       dv1;
   logic       dv2;
   logic       par_en;
   logic       par_bit;
   logic [7:0] p_data;
   logic       tx1;
   logic       busy1;
   logic       tx2;
   logic       busy2;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (dv1),
      .par_en     (par_en),
      .par_bit    (par_bit),
      .tx_out     (tx1),
      .busy       (busy1)
   );

   uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (dv2),
      .par_en     (par_en),
      .par_bit    (par_bit),
      .tx_out     (tx2),
      .busy       (busy2)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Pulse data_valid for one cycle; returns at the negedge of the START cycle.
   task automatic accept(input int which, input logic [7:0] d, input logic pe, input logic pb);
      @(negedge clk);
      p_data  = d;
      par_en  = pe;
      par_bit = pb;
      if (which == 0) dv1 = 1'b1;
      else            dv2 = 1'b1;
      @(negedge clk);
      dv1 = 1'b0;
      dv2 = 1'b0;
   endtask

   task automatic check_frame(input int which, input string tag, input string exp);
      for (int i = 0; i < exp.len(); i++) begin
         check($sformatf("%s tx[%0d]", tag, i), (which == 0) ? tx1 : tx2,
               (exp.substr(i, i) == "1") ? 1'b1 : 1'b0);
         check($sformatf("%s busy[%0d]", tag, i), (which == 0) ? busy1 : busy2, 1'b1);
         @(negedge clk);
      end
      check($sformatf("%s busy_end", tag), (which == 0) ? busy1 : busy2, 1'b0);
      check($sformatf("%s tx_end", tag), (which == 0) ? tx1 : tx2, 1'b1);
   endtask

   initial begin
      rst     = 1'b1;
      dv1     = 1'b0;
      dv2     = 1'b0;
      par_en  = 1'b0;
      par_bit = 1'b0;
      p_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("reset tx1", tx1, 1'b1);
      check("reset busy1", busy1, 1'b0);
      check("reset tx2", tx2, 1'b1);
      check("reset busy2", busy2, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Even and odd parity on 0xA5, then no parity on 0x01.
      accept(0, 8'hA5, 1'b1, 1'b0);
      check_frame(0, "a5_even", "01010010101");
      accept(0, 8'hA5, 1'b1, 1'b1);
      check_frame(0, "a5_odd", "01010010111");
      accept(0, 8'h01, 1'b0, 1'b0);
      check_frame(0, "01_nopar", "0100000001");

      // Request mid-frame is ignored; held request starts after one IDLE cycle.
      accept(0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         if (i == 4) begin
            dv1    = 1'b1;
            p_data = 8'hFF;
            par_en = 1'b0;
         end
         check($sformatf("busy_ign tx[%0d]", i), tx1, (i == 10) ? 1'b1 : 1'b0);
         check($sformatf("busy_ign busy[%0d]", i), busy1, 1'b1);
         @(negedge clk);
      end
      check("busy_ign idle_busy", busy1, 1'b0);
      check("busy_ign idle_tx", tx1, 1'b1);
      @(negedge clk);
      dv1 = 1'b0;
      check_frame(0, "held_ff", "0111111111");

      // Reset during DATA aborts the frame with the line left idle.
      accept(0, 8'hC3, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst tx", tx1, 1'b1);
      check("midrst busy", busy1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("midrst idle_tx[%0d]", i), tx1, 1'b1);
         check($sformatf("midrst idle_busy[%0d]", i), busy1, 1'b0);
      end
      accept(0, 8'h3C, 1'b1, 1'b0);
      check_frame(0, "3c_after_rst", "00011110001");

      // Reset and request on the same edge: the word is dropped.
      @(negedge clk);
      rst    = 1'b1;
      dv1    = 1'b1;
      p_data = 8'h55;
      @(negedge clk);
      rst = 1'b0;
      dv1 = 1'b0;
      check("rst_dv busy", busy1, 1'b0);
      check("rst_dv tx", tx1, 1'b1);
      @(negedge clk);
      check("rst_dv busy_next", busy1, 1'b0);
      check("rst_dv tx_next", tx1, 1'b1);

      // Two stop bits, 0x80 with even parity.
      accept(1, 8'h80, 1'b1, 1'b1);
      check_frame(1, "80_2stop", "000000001111");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
